// File: rtl/score_display_driver.sv
// Multi-digit seven-segment driver: captures a binary value, converts it to BCD
// (double-dabble, one bit per clock) or hex nibbles, and drives active-low segments.
//
// state   | meaning
// IDLE    | waiting for LOAD, display holds the last converted value
// CONVERT | shifting one value bit per cycle into the BCD accumulator
// UPDATE  | latching the new digits into the display registers
module score_display_driver #(
  parameter int VALUE_WIDTH = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    LOAD,
  input  logic [VALUE_WIDTH-1:0]  VALUE,
  input  logic                    MODE,
  input  logic                    BLANK_ZEROS,
  input  logic                    BLINK,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVERFLOW,
  output logic [7*NUM_DIGITS-1:0] HEX_OUT
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int LW = VALUE_WIDTH + 5;
  localparam int CW = $clog2(VALUE_WIDTH + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // base^NUM_DIGITS, saturated once it exceeds every representable input value
  function automatic logic [LW-1:0] digit_limit(input int base);
    logic [LW-1:0] p;
    p = LW'(1);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (p <= (LW'(1) << VALUE_WIDTH)) p = p * LW'(base);
    return p;
  endfunction

  localparam logic [LW-1:0] DEC_LIM = digit_limit(10);
  localparam logic [LW-1:0] HEX_LIM = digit_limit(16);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0011000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t state, state_n;

  logic [VALUE_WIDTH-1:0]    val_sh;
  logic [DW-1:0]             bcd;
  logic [CW-1:0]             cnt;
  logic                      mode_q;
  logic                      ovf_q;
  logic [DW-1:0]             digits;
  logic                      ovf_out;
  logic                      shown_q;
  logic                      done_q;
  logic [BW-1:0]             blink_cnt;
  logic                      phase_on;

  logic [DW-1:0]             bcd_adj;
  logic [DW+VALUE_WIDTH-1:0] shifted;
  logic [DW-1:0]             hex_dig;
  logic [DW-1:0]             new_digits;
  logic [DW-1:0]             sel_dig;
  logic                      sel_ovf;
  logic                      sel_valid;
  logic [7*NUM_DIGITS-1:0]   hex_n;
  logic                      ovf_cap;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (LOAD) state_n = MODE ? UPDATE : CONVERT;
      CONVERT: if (cnt == CW'(1)) state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  assign shifted = {bcd_adj, val_sh} << 1;

  for (genvar k = 0; k < DW; k++) begin : g_hex
    if (k < VALUE_WIDTH) begin : g_bit
      assign hex_dig[k] = val_sh[k];
    end else begin : g_pad
      assign hex_dig[k] = 1'b0;
    end
  end

  assign new_digits = mode_q ? hex_dig : bcd;
  assign ovf_cap    = MODE ? (LW'(VALUE) >= HEX_LIM) : (LW'(VALUE) >= DEC_LIM);

  // the display register sees the UPDATE result on the same edge the digits are latched
  assign sel_dig   = (state == UPDATE) ? new_digits : digits;
  assign sel_ovf   = (state == UPDATE) ? ovf_q : ovf_out;
  assign sel_valid = (state == UPDATE) || shown_q;

  always_comb begin
    logic       seen;
    logic [3:0] nib;
    hex_n = '1;
    seen  = 1'b0;
    nib   = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = sel_dig[4*i +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (sel_ovf)                              hex_n[7*i +: 7] = 7'b0111111;
      else if (BLANK_ZEROS && !seen && i != 0)  hex_n[7*i +: 7] = 7'b1111111;
      else                                      hex_n[7*i +: 7] = seg7(nib);
    end
    if (!sel_valid || (BLINK && !phase_on)) hex_n = '1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      val_sh    <= '0;
      bcd       <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      ovf_q     <= 1'b0;
      digits    <= '0;
      ovf_out   <= 1'b0;
      shown_q   <= 1'b0;
      done_q    <= 1'b0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
      HEX_OUT   <= '1;
    end else begin
      done_q  <= (state == UPDATE);
      HEX_OUT <= hex_n;
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      case (state)
        IDLE: begin
          if (LOAD) begin
            val_sh <= VALUE;
            mode_q <= MODE;
            bcd    <= '0;
            cnt    <= CW'(VALUE_WIDTH);
            ovf_q  <= ovf_cap;
          end
        end
        CONVERT: begin
          bcd    <= shifted[DW+VALUE_WIDTH-1:VALUE_WIDTH];
          val_sh <= shifted[VALUE_WIDTH-1:0];
          cnt    <= cnt - CW'(1);
        end
        UPDATE: begin
          digits  <= new_digits;
          ovf_out <= ovf_q;
          shown_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY     = (state == CONVERT);
  assign DONE     = done_q;
  assign OVERFLOW = ovf_out;

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver: two instances (3 and 2 digits) share stimulus and are
// compared with an arithmetic digit model.
module tb_score_display_driver;

  logic        clk = 1'b0;
  logic        rst, load, mode, blank_zeros, blink;
  logic [7:0]  value;
  logic        busy, done, ovf;
  logic [20:0] hex3;
  logic        busy2, done2, ovf2;
  logic [13:0] hex2;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int last_v = 0;
  bit last_m = 0;
  bit shown  = 0;
  logic [6:0] seg_tab [16];

  score_display_driver #(.VALUE_WIDTH(8), .NUM_DIGITS(3), .BLINK_DIV(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .LOAD(load), .VALUE(value), .MODE(mode),
    .BLANK_ZEROS(blank_zeros), .BLINK(blink), .BUSY(busy), .DONE(done),
    .OVERFLOW(ovf), .HEX_OUT(hex3));

  score_display_driver #(.VALUE_WIDTH(8), .NUM_DIGITS(2), .BLINK_DIV(4)) dut2 (
    .CLOCK_50(clk), .RESET(rst), .LOAD(load), .VALUE(value), .MODE(mode),
    .BLANK_ZEROS(blank_zeros), .BLINK(blink), .BUSY(busy2), .DONE(done2),
    .OVERFLOW(ovf2), .HEX_OUT(hex2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [20:0] model(input int v, input bit hexm, input int nd, input bit blank);
    int base, lim, msd, d, pw;
    logic [20:0] r;
    base = hexm ? 16 : 10;
    lim  = 1;
    for (int i = 0; i < nd; i++) lim *= base;
    r = '1;
    if (v >= lim) begin
      for (int i = 0; i < nd; i++) r[7*i +: 7] = 7'b0111111;
      return r;
    end
    msd = 0;
    pw  = 1;
    for (int i = 0; i < nd; i++) begin
      d = (v / pw) % base;
      if (d != 0) msd = i;
      pw *= base;
    end
    pw = 1;
    for (int i = 0; i < nd; i++) begin
      d = (v / pw) % base;
      r[7*i +: 7] = (blank && i > msd) ? 7'b1111111 : seg_tab[d];
      pw *= base;
    end
    return r;
  endfunction

  function automatic logic [20:0] exp_disp(input int nd);
    return shown ? model(last_v, last_m, nd, blank_zeros) : '1;
  endfunction

  task automatic check_display(input string tag);
    logic [20:0] e3, e2;
    e3 = exp_disp(3);
    e2 = exp_disp(2);
    chk({tag, "_hex3"}, 32'(hex3), 32'(e3));
    chk({tag, "_hex2"}, 32'(hex2), 32'(e2[13:0]));
  endtask

  task automatic do_load(input int v, input bit m);
    int lat, busy_n, k, exp_lat;
    bit got;
    logic [20:0] e3, e2;
    load  = 1'b1;
    value = 8'(v);
    mode  = m;
    tick();
    load = 1'b0;
    exp_lat = m ? 1 : 9;
    busy_n = 0;
    lat    = 0;
    got    = 0;
    k      = 0;
    while (!got && k <= 20) begin
      if (done) begin
        got = 1;
        lat = k;
      end else begin
        if (busy) busy_n++;
        check_display("hold");
        tick();
        k++;
      end
    end
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
    chk("done2_sync", 32'(done2), 32'(got));
    last_v = v;
    last_m = m;
    shown  = 1;
    e3 = model(v, m, 3, blank_zeros);
    e2 = model(v, m, 2, blank_zeros);
    chk("new_hex3", 32'(hex3), 32'(e3));
    chk("new_hex2", 32'(hex2), 32'(e2[13:0]));
    chk("ovf3", 32'(ovf), 32'(v >= (m ? 4096 : 1000)));
    chk("ovf2", 32'(ovf2), 32'(v >= (m ? 256 : 100)));
    tick();
    chk("done_pulse", 32'(done), 32'(0));
    check_display("after_done");
  endtask

  initial begin
    int dcount;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst = 1'b1; load = 1'b0; mode = 1'b0; blank_zeros = 1'b0; blink = 1'b0; value = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_hex", 32'(hex3), 32'(21'h1FFFFF));
    rst = 1'b0;
    tick();
    check_display("idle_dark");

    do_load(255, 0);
    blank_zeros = 1'b1;
    do_load(7, 0);
    chk("blank7", 32'(hex3), {11'd0, 7'b1111111, 7'b1111111, 7'b1111000});
    blank_zeros = 1'b0;
    tick();
    chk("unblank7", 32'(hex3), {11'd0, 7'b1000000, 7'b1000000, 7'b1111000});
    blank_zeros = 1'b1;
    do_load(0, 0);
    blank_zeros = 1'b0;
    do_load(8'hAB, 1);
    chk("hexAB", 32'(hex3), {11'd0, 7'b1000000, 7'b0001000, 7'b0000011});
    do_load(150, 0);
    chk("ovf150", 32'(hex2), {18'd0, 7'b0111111, 7'b0111111});
    do_load(42, 0);

    load = 1'b1; value = 8'd200; mode = 1'b0;
    tick();
    load = 1'b0;
    tick();
    tick();
    load = 1'b1; value = 8'd99;
    tick();
    load = 1'b0;
    chk("busy_ignore", 32'(busy), 32'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    shown = 0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_ovf", 32'(ovf), 32'(0));
    check_display("abort");
    dcount = 0;
    repeat (14) begin
      tick();
      if (done || done2) dcount++;
    end
    chk("no_done_after_abort", 32'(dcount), 32'(0));
    check_display("abort_dark");
    blank_zeros = 1'b1;
    do_load(99, 0);
    chk("blank99", 32'(hex3), {11'd0, 7'b1111111, 7'b0011000, 7'b0011000});

    for (int it = 0; it < 24; it++) begin
      blank_zeros = 1'($urandom_range(0, 1));
      do_load(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    blank_zeros = 1'b0;
    do_load(5, 0);
    blink = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [20:0] e3, e2;
      tick();
      e3 = (((edge_n - 1) / 4) % 2 == 1) ? 21'h1FFFFF : model(5, 0, 3, 0);
      e2 = (((edge_n - 1) / 4) % 2 == 1) ? 21'h1FFFFF : model(5, 0, 2, 0);
      chk("blink3", 32'(hex3), 32'(e3));
      chk("blink2", 32'(hex2), 32'(e2[13:0]));
    end
    blink = 1'b0;
    repeat (3) begin
      tick();
      check_display("blink_off");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
Parametrised multi-digit successor to the single-digit seven-segment decoder. Registers a binary score/value on a LOAD handshake. Converts it sequentially to BCD (double-dabble, one bit per clock) or passes hex nibbles through. Drives NUM_DIGITS active-low seven-segment outputs with leading-zero blanking, overflow indication and blink, and sits between game-state logic and the board HEX displays.

Parameters:
VALUE_WIDTH, 8, width of input binary value (>=1)
NUM_DIGITS, 3, number of seven-segment digits driven (>=1)
BLINK_DIV, 25000000, clock cycles per blink phase (on or off), >=1

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
LOAD  in  1  request: capture VALUE/MODE and start conversion; honoured only in IDLE
VALUE  in  VALUE_WIDTH  unsigned value to display
MODE  in  1  0 = decimal, 1 = hexadecimal; sampled with LOAD
BLANK_ZEROS  in  1  1 = blank leading zero digits (live, not sampled)
BLINK  in  1  1 = gate all segments off during blink off-phase (live)
BUSY  out  1  high while a conversion is in progress
DONE  out  1  one-cycle pulse when HEX_OUT holds the new value
OVERFLOW  out  1  value not representable in NUM_DIGITS digits; held until next DONE
HEX_OUT  out  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit i at [7i+6:7i], digit 0 least significant

Behaviour:
- Reset (RESET high at a rising edge): state IDLE, BUSY=0, DONE=0, OVERFLOW=0, HEX_OUT all 1s (dark), blink counter 0, blink phase = on. Reset overrides LOAD and aborts any conversion in flight; stored digits are discarded.
- States: IDLE, CONVERT, UPDATE.
- IDLE: on LOAD=1, capture VALUE and MODE, clear the BCD accumulator, and set BUSY=1.
  - Decimal mode: go to CONVERT with bit counter = VALUE_WIDTH.
  - Hex mode: go directly to UPDATE.
- LOAD while BUSY=1 is ignored. LOAD is not queued.
- CONVERT, each cycle:
  - Add 3 to every BCD nibble >= 5.
  - Shift {BCD, remaining value} left by one.
  - Decrement the counter; on the last bit go to UPDATE.
  - Takes exactly VALUE_WIDTH cycles.
- UPDATE, one cycle:
  - Load the digit registers and encode them into HEX_OUT.
  - DONE=1 for this cycle only; BUSY=0 from the next cycle; return to IDLE.
- Latency, counted from the LOAD edge (edge 0): new HEX_OUT and DONE are visible after edge VALUE_WIDTH+1 in decimal mode and after edge 1 in hex mode. BUSY is high for exactly that many cycles minus one.
- Overflow is evaluated on the captured value at LOAD:
  - Decimal: value > 10^NUM_DIGITS - 1.
  - Hex: value > 16^NUM_DIGITS - 1.
  - Effect: every digit shows 0111111 (dash) and OVERFLOW=1. Blanking does not apply to dashes.
- Encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (BLANK_ZEROS=1): every digit above the most significant non-zero digit outputs 1111111. Digit 0 is never blanked, so value 0 shows a single "0". Changing BLANK_ZEROS takes effect on HEX_OUT one cycle later, without LOAD.
- Blink: a free-running counter wraps at BLINK_DIV-1 and toggles the phase on wrap.
  - BLINK=1 and phase off: HEX_OUT all 1s.
  - Otherwise: HEX_OUT shows the stored digits.
  - Gating applies one cycle after a BLINK or phase change. The counter runs regardless of BLINK.
- HEX_OUT is fully registered (no combinational path from inputs). HEX_OUT holds the previous value throughout CONVERT.

Test Plan:
- Decimal, VALUE_WIDTH=8, NUM_DIGITS=3: LOAD with VALUE=255, BLANK_ZEROS=0 -> DONE pulse after edge 9. HEX_OUT digit2..0 = 0100100, 0010010, 0010010. OVERFLOW=0. BUSY high 8 cycles.
- Leading-zero blanking: VALUE=7, decimal, BLANK_ZEROS=1 -> digits 1111111, 1111111, 1111000. Drop BLANK_ZEROS to 0 -> next cycle 1000000, 1000000, 1111000. VALUE=0 with blanking -> 1111111, 1111111, 1000000.
- Hex mode: VALUE=8'hAB, MODE=1, BLANK_ZEROS=0 -> DONE after edge 1. Digits 1000000, 0001000, 0000011.
- Overflow: NUM_DIGITS=2, decimal VALUE=150 -> both digits 0111111, OVERFLOW=1. Next LOAD of 42 -> 0011001, 0100100, OVERFLOW=0.
- Reset mid-conversion and LOAD-while-busy:
  - LOAD 200; second LOAD of 99 at cycle 3 is ignored.
  - RESET at cycle 5 -> next cycle BUSY=0, DONE never pulses, HEX_OUT all 1s.
  - Fresh LOAD of 99 -> DONE after edge 9, digits 1111111, 0011000, 0011000 with blanking.
- Blink: BLINK_DIV=4, BLINK=1, value 5 displayed -> HEX_OUT alternates between shown and all-1s every 4 cycles. BLINK=0 -> steady display within one cycle.
